// File: rtl/branch_pkg.sv
// Shared encodings for the branch controller: opcodes, FSM states and the PC step.
package branch_pkg;

   typedef enum logic [2:0] {
      OP_BEQ  = 3'd0,
      OP_BNE  = 3'd1,
      OP_BLTZ = 3'd2,
      OP_BLEZ = 3'd3,
      OP_BGTZ = 3'd4,
      OP_BGEZ = 3'd5,
      OP_J    = 3'd6,
      OP_RSVD = 3'd7
   } br_op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_OPS = 2'd1,
      RESOLVE  = 2'd2,
      REDIRECT = 2'd3
   } br_state_e;

   localparam int unsigned PC_INC = 4;

   function automatic logic op_needs_rt(input br_op_e op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   // Unconditional and reserved ops never look at operands.
   function automatic logic op_skips_ops(input br_op_e op);
      return (op == OP_J) || (op == OP_RSVD);
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation; taken is forced low when en is low.
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             en,
   input  br_op_e           op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             taken
);

   logic w_rs_neg;
   logic w_rs_zero;
   logic w_cond;

   assign w_rs_neg  = rs[WIDTH-1];
   assign w_rs_zero = (rs == '0);

   always_comb begin
      w_cond = 1'b0;
      case (op)
         OP_BEQ:  w_cond = (rs == rt);
         OP_BNE:  w_cond = (rs != rt);
         OP_BLTZ: w_cond = w_rs_neg;
         OP_BLEZ: w_cond = w_rs_neg || w_rs_zero;
         OP_BGTZ: w_cond = !w_rs_neg && !w_rs_zero;
         OP_BGEZ: w_cond = !w_rs_neg;
         OP_J:    w_cond = 1'b1;
         default: w_cond = 1'b0;
      endcase
   end

   assign taken = en && w_cond;

endmodule

// File: rtl/branch_controller.sv
// Branch resolution controller: accepts a branch, waits for operands, resolves,
// and drives a held redirect to fetch until it is acknowledged.
module branch_controller
   import branch_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OFFW  = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_op,
   input  logic [WIDTH-1:0] br_pc,
   input  logic [OFFW-1:0]  br_off,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             rs_ready,
   input  logic             rt_ready,
   input  logic             kill,
   output logic             stall,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc,
   input  logic             fetch_ack,
   output logic             flush,
   output logic             done,
   output logic [15:0]      taken_cnt,
   output logic [15:0]      ntaken_cnt
);

   br_state_e        r_state;
   br_state_e        w_state_nxt;
   br_op_e           r_op;
   logic [WIDTH-1:0] r_pc;
   logic [OFFW-1:0]  r_off;
   logic [WIDTH-1:0] r_rs;
   logic [WIDTH-1:0] r_rt;
   logic [WIDTH-1:0] r_redirect_pc;
   logic             r_flush;
   logic             r_done;
   logic [15:0]      r_taken_cnt;
   logic [15:0]      r_ntaken_cnt;

   logic             w_accept;
   logic             w_ops_ok;
   logic             w_resolve;
   logic             w_taken;
   logic [WIDTH-1:0] w_off_ext;
   logic [WIDTH-1:0] w_target;

   assign w_accept  = br_ready && br_valid;
   assign w_ops_ok  = rs_ready && (!op_needs_rt(r_op) || rt_ready);
   assign w_resolve = (r_state == RESOLVE) && !kill;

   // Word offset: sign-extend, scale by 4, add to pc+4; overflow wraps silently.
   assign w_off_ext = {{(WIDTH-OFFW){r_off[OFFW-1]}}, r_off};
   assign w_target  = r_pc + WIDTH'(PC_INC) + (w_off_ext << 2);

   branch_cond_eval #(
      .WIDTH (WIDTH)
   ) u_cond (
      .en    (r_state == RESOLVE),
      .op    (r_op),
      .rs    (r_rs),
      .rt    (r_rt),
      .taken (w_taken)
   );

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      br_ready       = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      case (r_state)
         IDLE: begin
            br_ready = !kill;
            if (br_valid)
               w_state_nxt = op_skips_ops(br_op_e'(br_op)) ? RESOLVE : WAIT_OPS;
         end
         WAIT_OPS: begin
            stall = 1'b1;
            if (w_ops_ok) w_state_nxt = RESOLVE;
         end
         RESOLVE: begin
            stall       = 1'b1;
            w_state_nxt = w_taken ? REDIRECT : IDLE;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            if (fetch_ack) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (kill) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_op          <= OP_BEQ;
         r_pc          <= '0;
         r_off         <= '0;
         r_rs          <= '0;
         r_rt          <= '0;
         r_redirect_pc <= '0;
         r_flush       <= 1'b0;
         r_done        <= 1'b0;
         r_taken_cnt   <= '0;
         r_ntaken_cnt  <= '0;
      end else begin
         r_flush <= 1'b0;
         r_done  <= 1'b0;
         if (w_accept) begin
            r_op  <= br_op_e'(br_op);
            r_pc  <= br_pc;
            r_off <= br_off;
         end
         if ((r_state == WAIT_OPS) && w_ops_ok && !kill) begin
            r_rs <= rs;
            r_rt <= rt;
         end
         if (w_resolve) begin
            if (w_taken) begin
               r_redirect_pc <= w_target;
               r_flush       <= 1'b1;
               if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 16'd1;
            end else begin
               r_done <= 1'b1;
               if (r_ntaken_cnt != '1) r_ntaken_cnt <= r_ntaken_cnt + 16'd1;
            end
         end
         if ((r_state == REDIRECT) && fetch_ack && !kill) r_done <= 1'b1;
      end
   end

   assign redirect_pc = r_redirect_pc;
   assign flush       = r_flush;
   assign done        = r_done;
   assign taken_cnt   = r_taken_cnt;
   assign ntaken_cnt  = r_ntaken_cnt;

endmodule

// File: tb/tb_branch_controller.sv
// Directed bench for branch_controller: stimulus pushes expected redirect/done
// events into a queue that an independent negedge monitor pops and checks.
module tb_branch_controller;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned OFFW  = 16;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             br_valid = 1'b0;
   logic             br_ready;
   logic [2:0]       br_op = '0;
   logic [WIDTH-1:0] br_pc = '0;
   logic [OFFW-1:0]  br_off = '0;
   logic [WIDTH-1:0] rs = '0;
   logic [WIDTH-1:0] rt = '0;
   logic             rs_ready = 1'b0;
   logic             rt_ready = 1'b0;
   logic             kill = 1'b0;
   logic             stall;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;
   logic             fetch_ack = 1'b0;
   logic             flush;
   logic             done;
   logic [15:0]      taken_cnt;
   logic [15:0]      ntaken_cnt;

   always #5 clk = ~clk;

   branch_controller #(
      .WIDTH (WIDTH),
      .OFFW  (OFFW)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_op          (br_op),
      .br_pc          (br_pc),
      .br_off         (br_off),
      .rs             (rs),
      .rt             (rt),
      .rs_ready       (rs_ready),
      .rt_ready       (rt_ready),
      .kill           (kill),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_ack      (fetch_ack),
      .flush          (flush),
      .done           (done),
      .taken_cnt      (taken_cnt),
      .ntaken_cnt     (ntaken_cnt)
   );

   typedef struct packed {
      logic        is_redir;
      logic [31:0] pc;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_redir(input logic [31:0] pc);
      exp_q.push_back('{is_redir: 1'b1, pc: pc});
   endtask

   task automatic push_done();
      exp_q.push_back('{is_redir: 1'b0, pc: 32'h0});
   endtask

   // Monitor: every flush or done pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (resetn && (flush || done)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got flush=%0b done=%0b, expected no event", flush, done);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_kind_is_redirect", {31'd0, flush}, {31'd0, mon_e.is_redir});
            if (flush) begin
               check("redirect_pc", redirect_pc, mon_e.pc);
               check("redirect_valid_on_flush", {31'd0, redirect_valid}, 32'd1);
            end
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] off);
      int unsigned n = 0;
      @(negedge clk);
      while (!br_ready && n < 32) begin
         @(negedge clk);
         n++;
      end
      if (!br_ready) check("br_ready_timeout", 32'd0, 32'd1);
      br_valid = 1'b1;
      br_op    = op;
      br_pc    = pc;
      br_off   = off;
      @(posedge clk);
      #1 br_valid = 1'b0;
   endtask

   task automatic wait_flush(output int unsigned n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!flush && n < 32);
      if (!flush) check("flush_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(output int unsigned n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 32);
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic ack_now();
      fetch_ack = 1'b1;
      @(posedge clk);
      #1 fetch_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_ctl_outputs", {28'd0, stall, redirect_valid, flush, done}, 32'd0);
      check("reset_redirect_pc", redirect_pc, 32'd0);
      check("reset_counters", {taken_cnt, ntaken_cnt}, 32'd0);
      check("reset_br_ready", {31'd0, br_ready}, 32'd1);
      resetn = 1'b1;

      // BEQ taken: 0x100 + 4 + (3<<2) = 0x110, redirect held until ack
      rs = 32'h5; rt = 32'h5; rs_ready = 1'b1; rt_ready = 1'b1;
      push_redir(32'h110);
      push_done();
      issue(3'd0, 32'h100, 16'h0003);
      wait_flush(n);
      check("beq_flush_latency", n, 32'd3);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("beq_redirect_held", {stall, flush, redirect_valid, redirect_pc[28:0]},
               {3'b001, 29'h110});
      end
      ack_now();
      check("beq_done_after_ack", {31'd0, done}, 32'd1);
      check("beq_redirect_dropped", {31'd0, redirect_valid}, 32'd0);
      check("beq_taken_cnt", {16'd0, taken_cnt}, 32'd1);

      // BNE not taken: done 3 cycles after accept
      rs = 32'h7; rt = 32'h7;
      push_done();
      issue(3'd1, 32'h140, 16'h0010);
      wait_done(n);
      check("bne_done_latency", n, 32'd3);
      check("bne_ntaken_cnt", {16'd0, ntaken_cnt}, 32'd1);
      check("bne_no_redirect", {31'd0, redirect_valid}, 32'd0);

      // BGTZ rs=0 with rs_ready low for 4 cycles
      rs = 32'h0; rs_ready = 1'b0; rt_ready = 1'b0;
      push_done();
      issue(3'd4, 32'h180, 16'h0004);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bgtz_stall_waiting", {30'd0, stall, done}, 32'd2);
      end
      rs_ready = 1'b1;
      wait_done(n);
      check("bgtz_done_after_ready", n, 32'd2);
      check("bgtz_ntaken_cnt", {16'd0, ntaken_cnt}, 32'd2);

      // BLTZ most-negative rs, target wraps to 0; ack in first REDIRECT cycle
      rs = 32'h8000_0000;
      push_redir(32'h0);
      push_done();
      issue(3'd2, 32'h0, 16'hFFFF);
      wait_flush(n);
      ack_now();
      check("bltz_first_cycle_ack_done", {31'd0, done}, 32'd1);
      check("bltz_taken_cnt", {16'd0, taken_cnt}, 32'd2);

      // J taken then killed alongside fetch_ack: 0x200 + 4 - 8 = 0x1FC
      push_redir(32'h1FC);
      issue(3'd6, 32'h200, 16'hFFFE);
      wait_flush(n);
      check("j_flush_latency", n, 32'd2);
      kill = 1'b1; fetch_ack = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0; fetch_ack = 1'b0;
      @(negedge clk);
      check("kill_state", {29'd0, done, redirect_valid, br_ready}, 32'd1);
      check("kill_taken_cnt", {16'd0, taken_cnt}, 32'd3);
      repeat (3) @(negedge clk);

      // Reserved opcode resolves not-taken without waiting for operands
      rs_ready = 1'b0;
      push_done();
      issue(3'd7, 32'h240, 16'h0001);
      wait_done(n);
      check("rsvd_done_latency", n, 32'd2);
      check("rsvd_ntaken_cnt", {16'd0, ntaken_cnt}, 32'd3);

      // Saturation of taken_cnt
      @(negedge clk);
      force dut.r_taken_cnt = 16'hFFFE;
      #1 release dut.r_taken_cnt;
      push_redir(32'h4);
      push_done();
      issue(3'd6, 32'h0, 16'h0000);
      wait_flush(n);
      ack_now();
      check("sat_reach_ffff", {16'd0, taken_cnt}, 32'h0000_FFFF);
      push_redir(32'h18);
      push_done();
      issue(3'd6, 32'h10, 16'h0001);
      wait_flush(n);
      ack_now();
      check("sat_hold_ffff", {16'd0, taken_cnt}, 32'h0000_FFFF);

      // Reset while in WAIT_OPS discards the branch
      rs_ready = 1'b0;
      issue(3'd5, 32'h300, 16'h0002);
      @(negedge clk);
      check("pre_reset_stall", {31'd0, stall}, 32'd1);
      resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midreset_ctl_outputs", {28'd0, stall, redirect_valid, flush, done}, 32'd0);
      check("midreset_redirect_pc", redirect_pc, 32'd0);
      check("midreset_counters", {taken_cnt, ntaken_cnt}, 32'd0);
      resetn = 1'b1;
      rs_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("post_reset_idle", {30'd0, stall, br_ready}, 32'd1);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
